branch_predictor: RTL and testbench

- Direct-mapped branch target buffer (BTB) with parametrised saturating direction counters.
- Sits beside the PC register in IF and gives a predicted next PC every cycle.
- Branch/jump-register resolution in the EX/MEM stage updates the table and gets a mispredict flag plus the corrected PC.
- Replaces the current always-not-taken policy and its flush on every taken branch.

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/sat_counter.sv | 30 +++
 rtl/branch_predictor.sv | 121 ++++++++++++
 tb/tb_branch_predictor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types and defaults for the branch predictor
package cpu_types_pkg;

    // Default branch predictor geometry
    localparam int BP_ENTRIES_DEF = 16;
    localparam int BP_CTR_W_DEF   = 2;
    localparam int BP_ADDR_W_DEF  = 32;
    localparam int BP_IDX_W_DEF   = $clog2(BP_ENTRIES_DEF);
    localparam int BP_TAG_W_DEF   = BP_ADDR_W_DEF - BP_IDX_W_DEF - 2;

    // One BTB entry at the default geometry
    typedef struct packed {
        logic                     valid;
        logic [BP_TAG_W_DEF-1:0]  tag;
        logic [BP_ADDR_W_DEF-1:0] target;
        logic [BP_CTR_W_DEF-1:0]  ctr;
    } bp_entry_t;

    // Counter value written on allocation: weakly taken (MSB set, rest clear)
    function automatic int bp_weak_taken(input int ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up/down direction counter with load
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    output logic [CTR_W-1:0] q
);

    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_MIN = '0;

    // Load takes priority; inc/dec stop at the rails instead of wrapping
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (inc && (q != CTR_MAX)) begin
            q <= q + CTR_W'(1);
        end else if (dec && (q != CTR_MIN)) begin
            q <= q - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating direction counters
module branch_predictor
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES_DEF,
    parameter int CTR_W   = BP_CTR_W_DEF,
    parameter int ADDR_W  = BP_ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_next_pc,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] correct_pc,
    input  logic              inv_all,
    output logic [31:0]       mispred_cnt,
    output logic [31:0]       update_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(bp_weak_taken(CTR_W));

    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [ADDR_W-1:0] tgt_q   [ENTRIES];
    logic [CTR_W-1:0]  ctr_q   [ENTRIES];

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic              upd_we;

    // Word-aligned PCs: the two low bits never participate in index or tag
    wire unused_pc_lsbs = ^{lk_pc[1:0], upd_pc[1:0]};

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

    // Lookup reads registered state only, so a same-cycle update is not bypassed
    always_comb begin
        lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken   = lk_hit && ctr_q[lk_idx][CTR_W-1];
        lk_next_pc = lk_taken ? tgt_q[lk_idx] : (lk_pc + ADDR_W'(4));
    end

    // Resolution check: direction wrong, or taken with the wrong target
    always_comb begin
        mispredict = upd_en && ((upd_pred_taken != upd_taken) ||
                                (upd_taken && (upd_pred_target != upd_target)));
        correct_pc = upd_taken ? upd_target : (upd_pc + ADDR_W'(4));
    end

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    // inv_all suppresses every table write in its cycle
    assign upd_we  = upd_en && !inv_all;

    // Valid/tag/target storage; a taken update either refreshes the hit entry or
    // allocates over whatever aliases this index, and both write the same fields
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
            end
        end else if (inv_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_en && upd_taken) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            tgt_q[upd_idx]   <= upd_target;
        end
    end

    // One direction counter per entry; only the addressed one moves
    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        logic sel;
        assign sel = upd_we && (upd_idx == IDX_W'(g));

        sat_counter #(
            .CTR_W (CTR_W)
        ) u_ctr (
            .CLK      (CLK),
            .nRST     (nRST),
            .inc      (sel && upd_hit && upd_taken),
            .dec      (sel && upd_hit && !upd_taken),
            .load     (sel && !upd_hit && upd_taken),
            .load_val (CTR_WEAK),
            .q        (ctr_q[g])
        );
    end

    // Statistics count every upd_en pulse, including ones that collide with inv_all
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            update_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (upd_en) begin
            update_cnt <= update_cnt + 32'd1;
            if (mispredict) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized and directed bench for branch_predictor
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] lk_pc;
    logic        lk_hit;
    logic        lk_taken;
    logic [31:0] lk_next_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic        inv_all;
    logic [31:0] mispred_cnt;
    logic [31:0] update_cnt;

    int n_vec = 0;
    int n_mis = 0;

    always #5 CLK = ~CLK;

    branch_predictor #(.ENTRIES(16), .CTR_W(2), .ADDR_W(32)) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .lk_pc           (lk_pc),
        .lk_hit          (lk_hit),
        .lk_taken        (lk_taken),
        .lk_next_pc      (lk_next_pc),
        .upd_en          (upd_en),
        .upd_pc          (upd_pc),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .mispredict      (mispredict),
        .correct_pc      (correct_pc),
        .inv_all         (inv_all),
        .mispred_cnt     (mispred_cnt),
        .update_cnt      (update_cnt)
    );

    // Reference model: a table of remembered branches keyed by (pc/4) mod 16
    bit          m_valid [16];
    logic [31:0] m_tagv  [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int unsigned m_upd;
    int unsigned m_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> 6;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tagv[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_tagv[i]  = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 0;
        end
        m_upd = 0;
        m_mis = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: drive after negedge, check comb outputs, clock, advance model, check stats
    task automatic step(input logic [31:0] lpc, input bit ue, input logic [31:0] upc,
                        input bit ptk, input logic [31:0] ptgt, input bit tk,
                        input logic [31:0] tgt, input bit inv);
        bit emis;
        int j;
        @(negedge CLK);
        lk_pc = lpc; upd_en = ue; upd_pc = upc; upd_pred_taken = ptk;
        upd_pred_target = ptgt; upd_taken = tk; upd_target = tgt; inv_all = inv;
        #1;
        chk("lk_hit", 32'(lk_hit), 32'(m_hit(lpc)));
        chk("lk_taken", 32'(lk_taken), 32'(m_taken(lpc)));
        chk("lk_next_pc", lk_next_pc, m_next(lpc));
        emis = ue && ((ptk != tk) || (tk && (ptgt != tgt)));
        chk("mispredict", 32'(mispredict), 32'(emis));
        chk("correct_pc", correct_pc, tk ? tgt : upc + 32'd4);
        @(posedge CLK);
        if (ue) begin
            m_upd++;
            if (emis) m_mis++;
            if (!inv) begin
                j = idx_of(upc);
                if (m_hit(upc)) begin
                    if (tk) begin
                        m_ctr[j] = (m_ctr[j] + 1 > 3) ? 3 : m_ctr[j] + 1;
                        m_tgt[j] = tgt;
                    end else begin
                        m_ctr[j] = (m_ctr[j] - 1 < 0) ? 0 : m_ctr[j] - 1;
                    end
                end else if (tk) begin
                    m_valid[j] = 1;
                    m_tagv[j]  = tag_of(upc);
                    m_tgt[j]   = tgt;
                    m_ctr[j]   = 2;
                end
            end
        end
        if (inv) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
        end
        #1;
        upd_en = 1'b0; inv_all = 1'b0;
        chk("update_cnt", update_cnt, m_upd);
        chk("mispred_cnt", mispred_cnt, m_mis);
    endtask

    // Update whose piped prediction is what the table would have said for upc
    task automatic step_p(input logic [31:0] lpc, input logic [31:0] upc, input bit tk,
                          input logic [31:0] tgt, input bit inv);
        step(lpc, 1'b1, upc, m_taken(upc), m_next(upc), tk, tgt, inv);
    endtask

    task automatic look(input logic [31:0] lpc);
        step(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] rpc();
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    task automatic random_phase(input int n);
        logic [31:0] upc;
        logic [31:0] tgt;
        bit tk;
        bit ptk;
        logic [31:0] ptgt;
        for (int k = 0; k < n; k++) begin
            upc  = rpc();
            tk   = 1'($urandom_range(0, 1));
            tgt  = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
            ptk  = m_taken(upc);
            ptgt = m_next(upc);
            if ($urandom_range(0, 3) == 0) ptk = ~ptk;
            step(rpc(), 1'($urandom_range(0, 4) != 0), upc, ptk, ptgt, tk, tgt,
                 $urandom_range(0, 39) == 0);
        end
    endtask

    initial begin
        m_reset();
        nRST = 1'b0; lk_pc = 32'h40; upd_en = 1'b0; upd_pc = 32'h0;
        upd_pred_taken = 1'b0; upd_pred_target = 32'h0; upd_taken = 1'b0;
        upd_target = 32'h0; inv_all = 1'b0;
        #2;
        chk("rst_lk_hit", 32'(lk_hit), 32'h0);
        chk("rst_lk_next_pc", lk_next_pc, 32'h44);
        chk("rst_mispred_cnt", mispred_cnt, 32'h0);
        #10 nRST = 1'b1;

        look(32'h40);
        step(32'h40, 1'b1, 32'h40, 1'b0, 32'h44, 1'b1, 32'h100, 1'b0);
        look(32'h40);
        for (int k = 0; k < 3; k++) begin
            step_p(32'h40, 32'h40, 1'b0, 32'h0, 1'b0);
        end
        look(32'h40);
        step_p(32'h40, 32'h40, 1'b1, 32'h100, 1'b0);
        step_p(32'h40, 32'h40, 1'b1, 32'h100, 1'b0);
        look(32'h80);
        step_p(32'h80, 32'h80, 1'b1, 32'h200, 1'b0);
        look(32'h40);
        look(32'h80);
        step_p(32'h40, 32'h40, 1'b1, 32'h100, 1'b0);
        step_p(32'h40, 32'h40, 1'b1, 32'h180, 1'b0);
        look(32'h40);
        step_p(32'h40, 32'h40, 1'b1, 32'h300, 1'b1);
        look(32'h40);
        look(32'hFFFFFFFC);
        step_p(32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0);

        random_phase(300);

        // Reset mid-stream with a taken update pending across the edge
        @(negedge CLK);
        lk_pc = 32'h40; upd_en = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
        upd_target = 32'h500; upd_pred_taken = 1'b0;
        #2 nRST = 1'b0;
        #1;
        m_reset();
        chk("midrst_lk_hit", 32'(lk_hit), 32'h0);
        chk("midrst_lk_taken", 32'(lk_taken), 32'h0);
        chk("midrst_lk_next_pc", lk_next_pc, 32'h44);
        chk("midrst_update_cnt", update_cnt, 32'h0);
        chk("midrst_mispred_cnt", mispred_cnt, 32'h0);
        @(posedge CLK);
        #1 upd_en = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        look(32'h40);

        random_phase(150);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
